// File: rtl/mul_acc_stage.sv
// mul_acc_stage: sums COUNT consecutive unsigned products from a
// combinational multiplier into an ACC_W-bit accumulator. Products arrive
// on a valid/ready input handshake. Each finished batch sum is presented on
// a valid/ready output handshake.
//
// Optional build feature: define MUL_ACC_SAT_EN to make the accumulator
// saturate at 2^ACC_W-1 on carry-out. Without it, the accumulator wraps
// modulo 2^ACC_W. In both builds, out_ovf reports whether any carry-out
// occurred during the batch.
//
// Port names follow the surrounding MAC datapath (clk, rst_n, in_*, out_*).
module mul_acc_stage #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int COUNT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  // A counter wide enough to index 0..COUNT-1. The minimum width is 1 bit,
  // which covers the COUNT=1 case.
  localparam int                CNT_W    = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(COUNT - 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sticky;
  logic [ACC_W-1:0]   r_sum;
  logic               r_ovf;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_last_accept;
  logic               w_handshake;
  logic [ACC_W:0]     w_sum_ext;
  logic               w_carry;
  logic [ACC_W-1:0]   w_acc_add;
  logic               w_sticky_add;

  // Handshake qualifiers. These are decoded straight from the state
  // register, so they never depend on the next-state logic.
  assign w_accept      = in_valid  & (r_state == ST_ACCUM);
  assign w_last_accept = w_accept  & (r_cnt == LAST_CNT);
  assign w_handshake   = out_ready & (r_state == ST_DONE);

  // Add one zero-extended product. The extra top bit holds the carry-out.
  assign w_sum_ext    = {1'b0, r_acc} + (ACC_W + 1)'(in_prod);
  assign w_carry      = w_sum_ext[ACC_W];
  assign w_sticky_add = r_sticky | w_carry;

`ifdef MUL_ACC_SAT_EN
  // Once the accumulator is pinned at all-ones, every later nonzero add
  // carries again. Adding zero leaves it unchanged. So the accumulator
  // stays saturated for the rest of the batch.
  assign w_acc_add = w_carry ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
`else
  assign w_acc_add = w_sum_ext[ACC_W-1:0];
`endif

  // State register for the ACCUM/DONE handshake sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with <= so that every register
    // samples values from before the edge, regardless of block ordering.
    if (!rst_n) r_state <= ST_ACCUM;
    else        r_state <= w_state_next;
  end

  // Next-state and handshake outputs. A clear overrides everything.
  always_comb begin
    // NOTE: every output of this block gets a default first. Without the
    // defaults, a path that skips an assignment would infer a latch.
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    unique case (r_state)
      ST_ACCUM: begin
        w_in_ready = 1'b1;
        if (w_last_accept) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        // The return to ACCUM is registered. in_ready rises only on the
        // cycle after the output handshake, so there is no bypass path.
        if (w_handshake) w_state_next = ST_ACCUM;
      end
      default: w_state_next = ST_ACCUM;
    endcase
    if (clr) w_state_next = ST_ACCUM;
  end

  // Running batch state: accumulator, product counter and carry flag.
  // Everything is zeroed when the batch closes, so the next batch starts
  // fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else if (clr) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else if (w_last_accept) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else if (w_accept) begin
      r_acc    <= w_acc_add;
      r_cnt    <= r_cnt + CNT_W'(1);
      r_sticky <= w_sticky_add;
    end
  end

  // Result holding register. It loads on the closing accept and stays
  // stable through DONE, because no accept can occur while in_ready is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (w_last_accept) begin
      r_sum <= w_acc_add;
      r_ovf <= w_sticky_add;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_sum   = r_sum;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_mul_acc_stage.sv
// Bench for mul_acc_stage. It exercises three instances:
// - the default configuration;
// - an 8-bit accumulator with COUNT=2, to exercise overflow;
// - COUNT=1.
// Expected results come from a batch-level arithmetic model.
module tb_mul_acc_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance: PROD_W=8, ACC_W=16, COUNT=4.
  logic        clr, in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [7:0]  in_prod;
  logic [15:0] out_sum;

  // Overflow instance: ACC_W=8, COUNT=2.
  logic        p8_clr, p8_in_valid, p8_in_ready, p8_out_valid, p8_out_ready, p8_out_ovf;
  logic [7:0]  p8_in_prod;
  logic [7:0]  p8_out_sum;

  // Single-product instance: COUNT=1.
  logic        p1_clr, p1_in_valid, p1_in_ready, p1_out_valid, p1_out_ready, p1_out_ovf;
  logic [7:0]  p1_in_prod;
  logic [15:0] p1_out_sum;

  mul_acc_stage #(.PROD_W(8), .ACC_W(16), .COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  mul_acc_stage #(.PROD_W(8), .ACC_W(8), .COUNT(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(p8_clr),
    .in_valid(p8_in_valid), .in_ready(p8_in_ready), .in_prod(p8_in_prod),
    .out_valid(p8_out_valid), .out_ready(p8_out_ready),
    .out_sum(p8_out_sum), .out_ovf(p8_out_ovf)
  );

  mul_acc_stage #(.PROD_W(8), .ACC_W(16), .COUNT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(p1_clr),
    .in_valid(p1_in_valid), .in_ready(p1_in_ready), .in_prod(p1_in_prod),
    .out_valid(p1_out_valid), .out_ready(p1_out_ready),
    .out_sum(p1_out_sum), .out_ovf(p1_out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model for a batch. The model works from the plain integer
  // total of the batch. Any carry-out during the batch is equivalent to the
  // true total exceeding the accumulator maximum.
  function automatic int unsigned model_sum(input int unsigned total, input int w);
    int unsigned mx;
    mx = (32'd1 << w) - 1;
`ifdef MUL_ACC_SAT_EN
    return (total > mx) ? mx : total;
`else
    return total & mx;
`endif
  endfunction

  function automatic logic model_ovf(input int unsigned total, input int w);
    return total > ((32'd1 << w) - 1);
  endfunction

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic send(input logic [7:0] p);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_prod  = p;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic send8(input logic [7:0] p);
    int n;
    n = 0;
    p8_in_valid = 1'b1;
    p8_in_prod  = p;
    while (!p8_in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) check("send8_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    p8_in_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  r [4];
    logic [15:0] held;
    int unsigned total;
    int          d;

    clr = 0; in_valid = 0; in_prod = 0; out_ready = 0;
    p8_clr = 0; p8_in_valid = 0; p8_in_prod = 0; p8_out_ready = 0;
    p1_clr = 0; p1_in_valid = 0; p1_in_prod = 0; p1_out_ready = 0;

    // Reset state.
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", {16'd0, out_sum}, 32'd0);
    check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: basic batch, back-to-back, with out_ready held high.
    out_ready = 1'b1;
    send(8'd15); send(8'd225); send(8'd0);
    check("t1_no_early_valid", {31'd0, out_valid}, 32'd0);
    send(8'd1);
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_sum", {16'd0, out_sum}, model_sum(241, 16));
    check("t1_ovf", {31'd0, out_ovf}, {31'd0, model_ovf(241, 16)});
    check("t1_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("t1_valid_drop", {31'd0, out_valid}, 32'd0);
    check("t1_ready_back", {31'd0, in_ready}, 32'd1);

    // 2: backpressure. A pending product must be ignored while in DONE.
    out_ready = 1'b0;
    send4(8'd10, 8'd20, 8'd30, 8'd40);
    check("t2_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b1;
    in_prod  = 8'd77;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t2_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t2_hold_sum", {16'd0, out_sum}, model_sum(100, 16));
      check("t2_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t2_release_valid", {31'd0, out_valid}, 32'd0);
    check("t2_release_ready", {31'd0, in_ready}, 32'd1);
    // 77 is still presented and is accepted on the next edge.
    send4(8'd77, 8'd3, 8'd4, 8'd5);
    check("t2_next_sum", {16'd0, out_sum}, model_sum(89, 16));
    @(posedge clk); #1;

    // Random batches with random output backpressure.
    for (int b = 0; b < 8; b++) begin
      out_ready = 1'b0;
      total = 0;
      for (int k = 0; k < 4; k++) begin
        r[k] = 8'($urandom_range(0, 255));
        total += r[k];
      end
      send4(r[0], r[1], r[2], r[3]);
      check("rnd_valid", {31'd0, out_valid}, 32'd1);
      check("rnd_sum", {16'd0, out_sum}, model_sum(total, 16));
      check("rnd_ovf", {31'd0, out_ovf}, {31'd0, model_ovf(total, 16)});
      held = out_sum;
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        @(posedge clk); #1;
        check("rnd_stable", {16'd0, out_sum}, {16'd0, held});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("rnd_drop", {31'd0, out_valid}, 32'd0);
    end

    // 4: asynchronous reset in mid-batch. The previous result is nonzero.
    send(8'd50); send(8'd60);
    #2 rst_n = 1'b0;
    #1;
    check("t4_out_valid", {31'd0, out_valid}, 32'd0);
    check("t4_out_sum", {16'd0, out_sum}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send4(8'd1, 8'd2, 8'd3, 8'd4);
    check("t4_sum", {16'd0, out_sum}, model_sum(10, 16));
    @(posedge clk); #1;

    // 5: clear in DONE with a same-cycle output handshake.
    out_ready = 1'b0;
    send4(8'd100, 8'd100, 8'd100, 8'd100);
    check("t5_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("t5_valid_clr", {31'd0, out_valid}, 32'd0);
    check("t5_sum_clr", {16'd0, out_sum}, 32'd0);
    check("t5_ovf_clr", {31'd0, out_ovf}, 32'd0);
    check("t5_ready_clr", {31'd0, in_ready}, 32'd1);
    send4(8'd9, 8'd9, 8'd9, 8'd9);
    check("t5_sum", {16'd0, out_sum}, model_sum(36, 16));
    @(posedge clk); #1;

    // Clear in mid-batch. A same-cycle input accept is discarded.
    send(8'd5); send(8'd6);
    clr = 1'b1; in_valid = 1'b1; in_prod = 8'd7;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    send4(8'd1, 8'd1, 8'd1, 8'd1);
    check("clr_mid_sum", {16'd0, out_sum}, model_sum(4, 16));
    @(posedge clk); #1;

    // 3: overflow with ACC_W=8 and COUNT=2, then random pairs.
    p8_out_ready = 1'b1;
    send8(8'd200); send8(8'd100);
    check("t3_valid", {31'd0, p8_out_valid}, 32'd1);
`ifdef MUL_ACC_SAT_EN
    check("t3_sum", {24'd0, p8_out_sum}, 32'd255);
`else
    check("t3_sum", {24'd0, p8_out_sum}, 32'd44);
`endif
    check("t3_ovf", {31'd0, p8_out_ovf}, 32'd1);
    @(posedge clk); #1;
    for (int b = 0; b < 10; b++) begin
      r[0] = 8'($urandom_range(0, 255));
      r[1] = 8'($urandom_range(0, 255));
      total = r[0] + r[1];
      send8(r[0]); send8(r[1]);
      check("p8_sum", {24'd0, p8_out_sum}, model_sum(total, 8));
      check("p8_ovf", {31'd0, p8_out_ovf}, {31'd0, model_ovf(total, 8)});
      @(posedge clk); #1;
      check("p8_drop", {31'd0, p8_out_valid}, 32'd0);
    end

    // 6: COUNT=1 with continuous random traffic. in_ready alternates.
    p1_out_ready = 1'b1;
    p1_in_valid  = 1'b1;
    r[0] = 8'($urandom_range(0, 255));
    p1_in_prod = r[0];
    check("t6_ready_init", {31'd0, p1_in_ready}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t6_valid", {31'd0, p1_out_valid}, 32'd1);
      check("t6_sum", {16'd0, p1_out_sum}, model_sum(r[0], 16));
      check("t6_ovf", {31'd0, p1_out_ovf}, 32'd0);
      check("t6_ready_low", {31'd0, p1_in_ready}, 32'd0);
      r[0] = 8'($urandom_range(0, 255));
      p1_in_prod = r[0];
      @(posedge clk); #1;
      check("t6_ready_high", {31'd0, p1_in_ready}, 32'd1);
      check("t6_valid_low", {31'd0, p1_out_valid}, 32'd0);
    end
    p1_in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
